// File: rtl/vga_pkg.sv
// Shared coordinate width, 640x480@60 default timing and sync polarity constants
// for the VGA timing generator.
package vga_pkg;

    localparam int COORD_W         = 11;
    localparam int COORD_MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int SYNC_ACTIVE_LOW  = 0;
    localparam int SYNC_ACTIVE_HIGH = 1;

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= pos < lo+len.
    function automatic logic in_window(coord_t pos, int lo, int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on en, resets to TOTAL-1 so the first
// enable lands on 0. count_nxt lets the parent register decodes with zero skew.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output coord_t count_nxt,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    assign wrap = en && (count == LAST);

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = wrap ? '0 : count + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered counters, syncs, data enable and strobes.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    if (H_TOTAL > COORD_MAX_TOTAL) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL exceeds 11-bit counter range");
    end
    if (V_TOTAL > COORD_MAX_TOTAL) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL exceeds 11-bit counter range");
    end

    coord_t h_nxt, v_nxt;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pix_en),
        .count     (hcount),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (h_wrap),
        .count     (vcount),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    // Decode the next coordinates so flags and counters update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= in_window(h_nxt, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ON : ~SYNC_ON;
            vsync       <= in_window(v_nxt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ON : ~SYNC_ON;
            de          <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
